// File: rtl/operand_b_fwd.sv
// operand_b_fwd
//   Selects operand B for the EX stage: sign/zero-extended immediate, a
//   forwarded register value, or zero. Tracks FWD_DEPTH in-flight writers in a
//   small scoreboard and inserts a single-cycle stall on a load-use hazard
//   against the youngest in-flight instruction.
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   id_valid/op/rt/imm   decode-stage instruction fields
//   id_rt_data           register-file read of id_rt
//   id_dst/id_wen        destination of the decoded instruction
//   fwd_data             slice k-1 holds the result of tracked stage k
//   stall                hold decode this cycle (combinational)
//   ex_valid/ex_opb      registered operand B for EX
module operand_b_fwd #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter logic [5:0]  OP_ALU    = 6'h00,
  parameter logic [5:0]  OP_LW     = 6'h23,
  parameter logic [5:0]  OP_SW     = 6'h2B,
  parameter logic [5:0]  OP_ADDI   = 6'h08,
  parameter logic [5:0]  OP_ANDI   = 6'h0C,
  parameter logic [5:0]  OP_ORI    = 6'h0D,
  parameter logic [5:0]  OP_BEQ    = 6'h04,
  parameter logic [5:0]  OP_J      = 6'h02,
  parameter logic [5:0]  OP_JAL    = 6'h03
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [5:0]                  id_op,
  input  logic [REG_AW-1:0]           id_rt,
  input  logic [15:0]                 id_imm,
  input  logic [DATA_W-1:0]           id_rt_data,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic                        id_wen,
  input  logic [FWD_DEPTH*DATA_W-1:0] fwd_data,
  output logic                        stall,
  output logic                        ex_valid,
  output logic [DATA_W-1:0]           ex_opb
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e                             state_q;
  logic [FWD_DEPTH-1:0]               sb_v_q;
  logic [FWD_DEPTH-1:0]               sb_ld_q;
  logic [FWD_DEPTH-1:0][REG_AW-1:0]   sb_dst_q;
  logic                               ex_valid_q;
  logic [DATA_W-1:0]                  ex_opb_q;

  logic              is_imm_s, is_imm_z, is_reg;
  logic [DATA_W-1:0] reg_val, opb_d;
  logic              sb_v_d, sb_ld_d;

  // Operand source class decode; anything unlisted (J, JAL, unknown) is ZERO.
  always_comb begin
    is_imm_s = (id_op == OP_LW) || (id_op == OP_SW) || (id_op == OP_ADDI);
    is_imm_z = (id_op == OP_ANDI) || (id_op == OP_ORI);
    is_reg   = (id_op == OP_ALU) || (id_op == OP_BEQ);
  end

  // Walk oldest to youngest so the youngest matching writer wins.
  always_comb begin
    reg_val = id_rt_data;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (sb_v_q[k] && (sb_dst_q[k] == id_rt))
        reg_val = fwd_data[k*DATA_W +: DATA_W];
    end
    if (id_rt == '0) reg_val = '0;
  end

  always_comb begin
    opb_d = '0;
    if (is_imm_s)      opb_d = {{(DATA_W-16){id_imm[15]}}, id_imm};
    else if (is_imm_z) opb_d = {{(DATA_W-16){1'b0}}, id_imm};
    else if (is_reg)   opb_d = reg_val;
  end

  // Only a load in stage 1 is a hazard: one bubble moves it to stage 2 where
  // its result is on the forwarding bus. HOLD suppresses a repeat stall.
  assign stall = !reset && (state_q == RUN) && id_valid && is_reg &&
                 sb_v_q[0] && sb_ld_q[0] && (id_rt != '0) &&
                 (sb_dst_q[0] == id_rt);

  assign sb_v_d  = !stall && id_valid && id_wen && (id_dst != '0);
  assign sb_ld_d = id_op == OP_LW;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      sb_v_q     <= '0;
      sb_ld_q    <= '0;
      sb_dst_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_opb_q   <= '0;
    end else begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        sb_v_q[k]   <= sb_v_q[k-1];
        sb_ld_q[k]  <= sb_ld_q[k-1];
        sb_dst_q[k] <= sb_dst_q[k-1];
      end
      sb_v_q[0]   <= sb_v_d;
      sb_ld_q[0]  <= sb_ld_d;
      sb_dst_q[0] <= id_dst;
      // stall is never high in HOLD, so HOLD always returns to RUN.
      state_q     <= stall ? HOLD : RUN;
      ex_valid_q  <= stall ? 1'b0 : id_valid;
      ex_opb_q    <= stall ? '0 : opb_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_opb   = ex_opb_q;

endmodule

// File: tb/tb_operand_b_fwd.sv
module tb_operand_b_fwd;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset, id_valid, id_wen;
  logic [5:0]    id_op;
  logic [4:0]    id_rt, id_dst;
  logic [15:0]   id_imm;
  logic [DW-1:0] id_rt_data;
  logic [2*DW-1:0] fwd_data;
  logic          stall, ex_valid;
  logic [DW-1:0] ex_opb;

  operand_b_fwd dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op),
    .id_rt(id_rt), .id_imm(id_imm), .id_rt_data(id_rt_data),
    .id_dst(id_dst), .id_wen(id_wen), .fwd_data(fwd_data),
    .stall(stall), .ex_valid(ex_valid), .ex_opb(ex_opb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, vld;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] rtd;
    logic [4:0]  dst;
    logic        wen;
    logic [31:0] f1, f2;
    logic        es;
    logic        ev;
    logic [31:0] eo;
  } vec_t;

  typedef struct { logic v; logic [31:0] d; } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int checks = 0, failures = 0;

  localparam logic [5:0] ALU = 6'h00, LW = 6'h23, SW = 6'h2B, ADDI = 6'h08,
                         ORI = 6'h0D, BEQ = 6'h04, J = 6'h02;

  function automatic vec_t mk(logic rst, logic vld, logic [5:0] op,
      logic [4:0] rt, logic [15:0] imm, logic [31:0] rtd, logic [4:0] dst,
      logic wen, logic [31:0] f1, logic [31:0] f2, logic es, logic ev,
      logic [31:0] eo);
    vec_t v;
    v.rst = rst; v.vld = vld; v.op = op; v.rt = rt; v.imm = imm; v.rtd = rtd;
    v.dst = dst; v.wen = wen; v.f1 = f1; v.f2 = f2; v.es = es; v.ev = ev;
    v.eo = eo;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clock);
    reset = v.rst; id_valid = v.vld; id_op = v.op; id_rt = v.rt;
    id_imm = v.imm; id_rt_data = v.rtd; id_dst = v.dst; id_wen = v.wen;
    fwd_data = {v.f2, v.f1};
    #1;
    checks++;
    if (stall !== v.es) begin
      failures++;
      $display("FAIL %s stall: got %b want %b", nm, stall, v.es);
    end
    e.v = v.ev; e.d = v.eo;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      if (ex_valid !== e.v || ex_opb !== e.d) begin
        failures++;
        $display("FAIL %s ex: got v=%b opb=%h want v=%b opb=%h",
                 nm, ex_valid, ex_opb, e.v, e.d);
      end
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 0; id_op = 0; id_rt = 0; id_imm = 0;
    id_rt_data = 0; id_dst = 0; id_wen = 0; fwd_data = '0;

    //               rst vld op    rt  imm       rtd           dst wen f1            f2            es ev eo
    tbl.push_back(mk(1, 1, ADDI, 0, 16'h0001, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(0, 1, ADDI, 0, 16'hFFF0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 1, 32'hFFFF_FFF0));
    tbl.push_back(mk(0, 1, ORI,  0, 16'hFFF0, 32'h0,        0, 1, 32'h0,        32'h0,        0, 1, 32'h0000_FFF0));
    tbl.push_back(mk(0, 1, ALU,  2, 16'h0,    32'hAAAA,     5, 1, 32'h0,        32'h0,        0, 1, 32'hAAAA));
    tbl.push_back(mk(0, 1, ALU,  5, 16'h0,    32'hDEAD,     5, 1, 32'h1234,     32'h0,        0, 1, 32'h1234));
    tbl.push_back(mk(0, 1, ALU,  5, 16'h0,    32'hDEAD,     0, 0, 32'h1111,     32'h2222,     0, 1, 32'h1111));
    tbl.push_back(mk(0, 1, ALU,  5, 16'h0,    32'hDEAD,     0, 0, 32'h9999,     32'h3333,     0, 1, 32'h3333));
    tbl.push_back(mk(0, 1, LW,   3, 16'h0004, 32'h0,        7, 1, 32'h0,        32'h0,        0, 1, 32'h4));
    tbl.push_back(mk(0, 1, ALU,  7, 16'h0,    32'hDEAD,     8, 1, 32'h5555,     32'h6666,     1, 0, 32'h0));
    tbl.push_back(mk(0, 1, ALU,  7, 16'h0,    32'hDEAD,     8, 1, 32'h5555,     32'h7777,     0, 1, 32'h7777));
    tbl.push_back(mk(0, 1, LW,   3, 16'h8000, 32'h0,        9, 1, 32'h0,        32'h0,        0, 1, 32'hFFFF_8000));
    tbl.push_back(mk(0, 1, SW,   9, 16'h0010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h10));
    tbl.push_back(mk(0, 1, ALU,  0, 16'h0,    32'hFFFF_FFFF, 0, 1, 32'h0,       32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, 1, ALU,  0, 16'h0,    32'hFFFF_FFFF, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, 1, J,    9, 16'h0,    32'h1234,     0, 0, 32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, 0, ALU,  3, 16'h0,    32'hBEEF,     3, 1, 32'h0,        32'h0,        0, 0, 32'hBEEF));
    tbl.push_back(mk(0, 1, ALU,  3, 16'h0,    32'hCAFE,     0, 0, 32'h1,        32'h2,        0, 1, 32'hCAFE));
    tbl.push_back(mk(0, 1, 6'h3F,3, 16'h7777, 32'h1,        0, 0, 32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, 1, BEQ,  4, 16'h0,    32'h4444,     0, 0, 32'h0,        32'h0,        0, 1, 32'h4444));
    // IMM class after a load to the same register never stalls
    tbl.push_back(mk(0, 1, LW,   0, 16'h0002, 32'h0,       10, 1, 32'h0,        32'h0,        0, 1, 32'h2));
    tbl.push_back(mk(0, 1, ADDI,10, 16'h0003, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 32'h3));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while a hazard is present: stall must read 0, pipeline cleared.
    apply(mk(0, 1, LW,  0, 16'h0, 32'h0,    7, 1, 32'h0, 32'h0,    0, 1, 32'h0), "rst_ld");
    apply(mk(1, 1, ALU, 7, 16'h0, 32'h0,    0, 0, 32'h0, 32'h0,    0, 0, 32'h0), "rst_haz");
    apply(mk(0, 1, ALU, 7, 16'h0, 32'hABCD, 0, 0, 32'h0, 32'h9,    0, 1, 32'hABCD), "rst_clr");

    // Reset asserted in HOLD, then a fresh hazard must stall again (FSM in RUN).
    apply(mk(0, 1, LW,  0, 16'h0, 32'h0,    7, 1, 32'h0, 32'h0,    0, 1, 32'h0), "hold_ld");
    apply(mk(0, 1, ALU, 7, 16'h0, 32'h0,    0, 0, 32'h1, 32'h2,    1, 0, 32'h0), "hold_stall");
    apply(mk(1, 1, ALU, 7, 16'h0, 32'h0,    0, 0, 32'h1, 32'h2,    0, 0, 32'h0), "hold_rst");
    apply(mk(0, 1, LW,  0, 16'h0, 32'h0,    7, 1, 32'h0, 32'h0,    0, 1, 32'h0), "post_ld");
    apply(mk(0, 1, ALU, 7, 16'h0, 32'h0,    0, 0, 32'h1, 32'h2,    1, 0, 32'h0), "post_stall");
    apply(mk(0, 1, ALU, 7, 16'h0, 32'h0,    0, 0, 32'h1, 32'h5A5A, 0, 1, 32'h5A5A), "post_fwd");

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
